// File: rtl/rca_44_pkg.sv
// Shared constants for the rca_44 registered ripple-carry adder.
package rca_44_pkg;

   localparam int RCA_44_WIDTH_DEF = 4;
   localparam int RCA_44_WIDTH_MAX = 32;

   // Wide enough for the largest legal WIDTH plus carry; slice down at use.
   localparam logic [RCA_44_WIDTH_MAX:0] RCA_44_RST_VAL = 33'd0;

endpackage : rca_44_pkg

// File: rtl/rca_44_full_adder.sv
// One-bit full adder: the single stage of the rca_44 ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   logic p;

   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule : full_adder

// File: rtl/rca_44.sv
// Registered WIDTH-bit ripple-carry adder; one cycle latency, no handshake.
// Optional two's-complement overflow output enabled by macro RCA_44_OVF_EN.
module rca_44
   import rca_44_pkg::*;
#(
   parameter int WIDTH = RCA_44_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef RCA_44_OVF_EN
   ,
   output logic             ovf
`endif
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] sum;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (sum[i]),
         .co (c[i+1])
      );
   end

   // Output register for sum and carry; async reset clears without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s    <= RCA_44_RST_VAL[WIDTH-1:0];
         cout <= RCA_44_RST_VAL[WIDTH];
      end else begin
         s    <= sum;
         cout <= c[WIDTH];
      end
   end

`ifdef RCA_44_OVF_EN
   // Signed overflow: carry into the sign bit differs from carry out of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= RCA_44_RST_VAL[0];
      end else begin
         ovf <= c[WIDTH] ^ c[WIDTH-1];
      end
   end
`endif

endmodule : rca_44

// File: tb/tb_rca_44.sv
// Directed self-checking bench for rca_44 at the default WIDTH of 4.
module tb_rca_44;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         cin;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] s;
   logic         cout;
`ifdef RCA_44_OVF_EN
   logic         ovf;
`endif

   int total;
   int bad;

   rca_44 #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .cin  (cin),
      .a    (a),
      .b    (b),
      .s    (s),
      .cout (cout)
`ifdef RCA_44_OVF_EN
      ,
      .ovf  (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Drive one vector at the falling edge, check after the following rising edge.
   task automatic vec(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic vc, input logic [W-1:0] es, input logic ec, input logic eo);
      @(negedge clk);
      a   = va;
      b   = vb;
      cin = vc;
      @(posedge clk);
      #1;
      chk({tag, "_s"}, 32'(s), 32'(es));
      chk({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef RCA_44_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`endif
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      a     = 4'd0;
      b     = 4'd0;
      cin   = 1'b0;

      // Reset state, then inputs ignored while reset is held.
      #1;
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      a   = 4'd5;
      b   = 4'd6;
      cin = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_hold_s", 32'(s), 32'd0);
      chk("rst_hold_cout", 32'(cout), 32'd0);
`ifdef RCA_44_OVF_EN
      chk("rst_hold_ovf", 32'(ovf), 32'd0);
`endif

      // First edge after release registers the current inputs.
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("first_s", 32'(s), 32'd12);
      chk("first_cout", 32'(cout), 32'd0);

      // Directed vectors with hand-computed results.
      vec("v9p2", 4'd9, 4'd2, 1'b0, 4'd11, 1'b0, 1'b0);
      vec("max_wrap", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0);
      vec("v7p9", 4'd7, 4'd9, 1'b0, 4'd0, 1'b1, 1'b0);
      vec("zero_cin", 4'd0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0);
      vec("v7p1", 4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1);
      vec("v8p8", 4'd8, 4'd8, 1'b0, 4'd0, 1'b1, 1'b1);
      vec("v3p4c", 4'd3, 4'd4, 1'b1, 4'd8, 1'b0, 1'b1);

      // Output must hold while inputs move between edges.
      vec("pre_hold", 4'd9, 4'd2, 1'b0, 4'd11, 1'b0, 1'b0);
      @(negedge clk);
      a   = 4'd15;
      b   = 4'd15;
      cin = 1'b1;
      #2;
      a   = 4'd0;
      #1;
      chk("hold_s", 32'(s), 32'd11);
      chk("hold_cout", 32'(cout), 32'd0);

      // Exhaustive sweep, one vector per cycle.
      for (int ci = 0; ci < 2; ci++) begin
         for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
               @(negedge clk);
               a   = 4'(ia);
               b   = 4'(ib);
               cin = 1'(ci);
               @(posedge clk);
               #1;
               chk($sformatf("sweep_%0d_%0d_%0d", ia, ib, ci), 32'({cout, s}), 32'(ia + ib + ci));
`ifdef RCA_44_OVF_EN
               chk($sformatf("sweep_ovf_%0d_%0d_%0d", ia, ib, ci), 32'(ovf),
                   32'((a[3] == b[3]) && (s[3] != a[3])));
`endif
            end
         end
      end

      // Mid-stream asynchronous reset clears outputs immediately.
      vec("pre_rst", 4'd9, 4'd2, 1'b0, 4'd11, 1'b0, 1'b0);
      @(negedge clk);
      a   = 4'd15;
      b   = 4'd15;
      cin = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_s", 32'(s), 32'd0);
      chk("async_rst_cout", 32'(cout), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_edge_s", 32'(s), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      a   = 4'd1;
      b   = 4'd1;
      cin = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_s", 32'(s), 32'd2);
      chk("post_rst_cout", 32'(cout), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rca_44
